// File: rtl/pipe_memory_stage_param.sv
// Y86-64 memory stage: word-addressed data RAM with configurable access latency,
// stall handshake toward pipeline control, and address-error status to W.
module pipe_memory_stage_param #(
  parameter int DATA_W  = 64,
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        M_stat,
  input  logic [3:0]        M_icode,
  input  logic [DATA_W-1:0] M_valE,
  input  logic [DATA_W-1:0] M_valA,
  input  logic [3:0]        M_dstE,
  input  logic [3:0]        M_dstM,
  output logic [3:0]        m_stat,
  output logic [3:0]        m_icode,
  output logic [DATA_W-1:0] m_valE,
  output logic [DATA_W-1:0] m_valM,
  output logic [3:0]        m_dstE,
  output logic [3:0]        m_dstM,
  output logic              m_stall
);

  localparam int OFF_W = $clog2(DATA_W / 8);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((LATENCY > 0) ? LATENCY - 1 : 0);

  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;
  localparam logic [3:0] S_AOK    = 4'h1;
  localparam logic [3:0] S_ADR    = 4'h3;
  localparam logic [3:0] R_NONE   = 4'hF;

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [DATA_W-1:0]  r_mem [DEPTH];

  logic [3:0]         r_stat_p1, r_icode_p1, r_dstE_p1, r_dstM_p1;
  logic [DATA_W-1:0]  r_valE_p1, r_valM_p1;

  logic               w_wr_op, w_rd_op, w_mem_op, w_ok;
  logic [DATA_W-1:0]  w_addr;
  logic [IDX_W-1:0]   w_idx;
  logic               w_misalign, w_oob, w_err, w_go, w_stall, w_commit;
  logic [DATA_W-1:0]  w_rdata;

  // Decode and address check
  always_comb begin
    w_wr_op    = (M_icode == I_RMMOVQ) || (M_icode == I_PUSHQ) || (M_icode == I_CALL);
    w_rd_op    = (M_icode == I_MRMOVQ) || (M_icode == I_POPQ)  || (M_icode == I_RET);
    w_mem_op   = w_wr_op || w_rd_op;
    w_ok       = (M_stat == S_AOK);
    w_addr     = (M_icode == I_RET) ? M_valA : M_valE;
    w_idx      = w_addr[OFF_W+IDX_W-1:OFF_W];
    w_misalign = |w_addr[OFF_W-1:0];
    // Upper address bits beyond the RAM index, plus non-power-of-two depths
    w_oob      = (|w_addr[DATA_W-1:OFF_W+IDX_W]) ||
                 ({1'b0, w_idx} >= (IDX_W+1)'(DEPTH));
    w_err      = w_ok && w_mem_op && (w_misalign || w_oob);
    w_go       = w_ok && w_mem_op && !(w_misalign || w_oob);
  end

  // Latency FSM
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_stall     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_cnt_nxt = '0;
        if (w_go && (LATENCY > 0)) begin
          w_stall     = 1'b1;
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (r_cnt == CNT_LAST) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_stall   = 1'b1;
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign w_commit = w_go && !w_stall;
  assign w_rdata  = r_mem[w_idx];
  assign m_stall  = w_stall && !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // RAM is never cleared; a reset arriving mid-access suppresses the write
  always_ff @(posedge clk) begin
    if (w_commit && w_wr_op && !rst)
      r_mem[w_idx] <= M_valA;
  end

  // Stage boundary: M -> W
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stat_p1  <= S_AOK;
      r_icode_p1 <= I_NOP;
      r_valE_p1  <= '0;
      r_valM_p1  <= '0;
      r_dstE_p1  <= R_NONE;
      r_dstM_p1  <= R_NONE;
    end else if (w_stall) begin
      r_stat_p1  <= S_AOK;
      r_icode_p1 <= I_NOP;
      r_valE_p1  <= '0;
      r_valM_p1  <= '0;
      r_dstE_p1  <= R_NONE;
      r_dstM_p1  <= R_NONE;
    end else begin
      r_stat_p1  <= w_err ? S_ADR : M_stat;
      r_icode_p1 <= M_icode;
      r_valE_p1  <= M_valE;
      r_valM_p1  <= (w_commit && w_rd_op) ? w_rdata : '0;
      r_dstE_p1  <= M_dstE;
      r_dstM_p1  <= M_dstM;
    end
  end

  assign m_stat  = r_stat_p1;
  assign m_icode = r_icode_p1;
  assign m_valE  = r_valE_p1;
  assign m_valM  = r_valM_p1;
  assign m_dstE  = r_dstE_p1;
  assign m_dstM  = r_dstM_p1;

endmodule

// File: tb/tb_pipe_memory_stage_param.sv
// Directed bench for pipe_memory_stage_param: three instances (LATENCY 0, 2, 3)
// share one input bus; each scenario observes the instance it targets.
module tb_pipe_memory_stage_param;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  M_stat, M_icode, M_dstE, M_dstM;
  logic [63:0] M_valE, M_valA;

  logic [3:0]  o_stat  [3];
  logic [3:0]  o_icode [3];
  logic [63:0] o_valE  [3];
  logic [63:0] o_valM  [3];
  logic [3:0]  o_dstE  [3];
  logic [3:0]  o_dstM  [3];
  logic        o_stall [3];

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  pipe_memory_stage_param #(.DATA_W(64), .DEPTH(1024), .LATENCY(0)) u_lat0 (
    .clk(clk), .rst(rst), .M_stat(M_stat), .M_icode(M_icode), .M_valE(M_valE),
    .M_valA(M_valA), .M_dstE(M_dstE), .M_dstM(M_dstM), .m_stat(o_stat[0]),
    .m_icode(o_icode[0]), .m_valE(o_valE[0]), .m_valM(o_valM[0]),
    .m_dstE(o_dstE[0]), .m_dstM(o_dstM[0]), .m_stall(o_stall[0]));

  pipe_memory_stage_param #(.DATA_W(64), .DEPTH(1024), .LATENCY(2)) u_lat2 (
    .clk(clk), .rst(rst), .M_stat(M_stat), .M_icode(M_icode), .M_valE(M_valE),
    .M_valA(M_valA), .M_dstE(M_dstE), .M_dstM(M_dstM), .m_stat(o_stat[1]),
    .m_icode(o_icode[1]), .m_valE(o_valE[1]), .m_valM(o_valM[1]),
    .m_dstE(o_dstE[1]), .m_dstM(o_dstM[1]), .m_stall(o_stall[1]));

  pipe_memory_stage_param #(.DATA_W(64), .DEPTH(1024), .LATENCY(3)) u_lat3 (
    .clk(clk), .rst(rst), .M_stat(M_stat), .M_icode(M_icode), .M_valE(M_valE),
    .M_valA(M_valA), .M_dstE(M_dstE), .M_dstM(M_dstM), .m_stat(o_stat[2]),
    .m_icode(o_icode[2]), .m_valE(o_valE[2]), .m_valM(o_valM[2]),
    .m_dstE(o_dstE[2]), .m_dstM(o_dstM[2]), .m_stall(o_stall[2]));

  typedef struct {
    logic [3:0]  stat;
    logic [3:0]  icode;
    logic [63:0] valE;
    logic [63:0] valA;
    logic [3:0]  x_stat;
    logic [63:0] x_valM;
  } vec_t;

  vec_t vecs [16];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    else
      passed++;
  endtask

  task automatic drive(input logic [3:0] st, input logic [3:0] ic,
                       input logic [63:0] ve, input logic [63:0] va,
                       input logic [3:0] de, input logic [3:0] dm);
    M_stat = st; M_icode = ic; M_valE = ve; M_valA = va; M_dstE = de; M_dstM = dm;
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    drive(4'h1, 4'h1, 64'h0, 64'h0, 4'hF, 4'hF);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Presents one AOK access and holds it until the selected instance drops stall.
  task automatic run_op(input int sel, input logic [3:0] ic, input logic [63:0] ve,
                        input logic [63:0] va, output int edges);
    logic st;
    @(negedge clk);
    drive(4'h1, ic, ve, va, 4'hF, 4'hF);
    edges = 0;
    #1 st = o_stall[sel];
    @(posedge clk);
    edges++;
    while (st && edges < 20) begin
      #1 st = o_stall[sel];
      @(posedge clk);
      edges++;
    end
    #1;
  endtask

  initial begin
    int e;
    logic [3:0] de, dm;

    //            stat  icode  valE          valA          x_stat x_valM
    vecs[0]  = '{4'h1, 4'h4, 64'h40,   64'hDEAD, 4'h1, 64'h0};
    vecs[1]  = '{4'h1, 4'h5, 64'h40,   64'h0,    4'h1, 64'hDEAD};
    vecs[2]  = '{4'h1, 4'h6, 64'h77,   64'h5,    4'h1, 64'h0};
    vecs[3]  = '{4'h1, 4'h4, 64'h43,   64'hBAD,  4'h3, 64'h0};
    vecs[4]  = '{4'h1, 4'h5, 64'h40,   64'h0,    4'h1, 64'hDEAD};
    vecs[5]  = '{4'h1, 4'h4, 64'h0,    64'h1111, 4'h1, 64'h0};
    vecs[6]  = '{4'h1, 4'h4, 64'h2000, 64'hBAD,  4'h3, 64'h0};
    vecs[7]  = '{4'h1, 4'h5, 64'h0,    64'h0,    4'h1, 64'h1111};
    vecs[8]  = '{4'h1, 4'h5, 64'h2000, 64'h0,    4'h3, 64'h0};
    vecs[9]  = '{4'h1, 4'h4, 64'h80,   64'hAAAA, 4'h1, 64'h0};
    vecs[10] = '{4'h4, 4'hA, 64'h80,   64'h5555, 4'h4, 64'h0};
    vecs[11] = '{4'h1, 4'h5, 64'h80,   64'h0,    4'h1, 64'hAAAA};
    vecs[12] = '{4'h1, 4'hA, 64'h200,  64'h1234, 4'h1, 64'h0};
    vecs[13] = '{4'h1, 4'h9, 64'h208,  64'h200,  4'h1, 64'h1234};
    vecs[14] = '{4'h2, 4'h5, 64'h40,   64'h0,    4'h2, 64'h0};
    vecs[15] = '{4'h1, 4'h9, 64'h210,  64'h203,  4'h3, 64'h0};

    rst = 1'b1;
    drive(4'h1, 4'h1, 64'h0, 64'h0, 4'hF, 4'hF);
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst%0d_stat", k),  64'(o_stat[k]),  64'h1);
      chk($sformatf("rst%0d_icode", k), 64'(o_icode[k]), 64'h1);
      chk($sformatf("rst%0d_valE", k),  o_valE[k],       64'h0);
      chk($sformatf("rst%0d_valM", k),  o_valM[k],       64'h0);
      chk($sformatf("rst%0d_dstE", k),  64'(o_dstE[k]),  64'hF);
      chk($sformatf("rst%0d_dstM", k),  64'(o_dstM[k]),  64'hF);
      chk($sformatf("rst%0d_stall", k), 64'(o_stall[k]), 64'h0);
    end
    @(negedge clk);
    rst = 1'b0;

    // Single-cycle instance: every vector completes on the next edge with no stall
    for (int i = 0; i < 16; i++) begin
      de = 4'(i);
      dm = 4'(15 - i);
      @(negedge clk);
      drive(vecs[i].stat, vecs[i].icode, vecs[i].valE, vecs[i].valA, de, dm);
      #1 chk($sformatf("v%0d_stall", i), 64'(o_stall[0]), 64'h0);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_stat", i),  64'(o_stat[0]),  64'(vecs[i].x_stat));
      chk($sformatf("v%0d_icode", i), 64'(o_icode[0]), 64'(vecs[i].icode));
      chk($sformatf("v%0d_valE", i),  o_valE[0],       vecs[i].valE);
      chk($sformatf("v%0d_valM", i),  o_valM[0],       vecs[i].x_valM);
      chk($sformatf("v%0d_dstE", i),  64'(o_dstE[0]),  64'(de));
      chk($sformatf("v%0d_dstM", i),  64'(o_dstM[0]),  64'(dm));
    end

    // LATENCY=2: write, then read with two bubbles before the data
    reset_pulse();
    run_op(1, 4'h4, 64'h40, 64'hCAFE, e);
    chk("l2_wr_edges", 64'(e), 64'd3);
    chk("l2_wr_icode", 64'(o_icode[1]), 64'h4);
    @(negedge clk);
    drive(4'h1, 4'h5, 64'h40, 64'h0, 4'hF, 4'h7);
    #1 chk("l2_rd_stall0", 64'(o_stall[1]), 64'h1);
    @(posedge clk);
    #1;
    chk("l2_bub1_icode", 64'(o_icode[1]), 64'h1);
    chk("l2_bub1_dstM",  64'(o_dstM[1]),  64'hF);
    chk("l2_bub1_valM",  o_valM[1],       64'h0);
    chk("l2_rd_stall1",  64'(o_stall[1]), 64'h1);
    @(posedge clk);
    #1;
    chk("l2_bub2_icode", 64'(o_icode[1]), 64'h1);
    chk("l2_rd_stall2",  64'(o_stall[1]), 64'h0);
    @(posedge clk);
    #1;
    chk("l2_rd_icode", 64'(o_icode[1]), 64'h5);
    chk("l2_rd_valM",  o_valM[1],       64'hCAFE);
    chk("l2_rd_dstM",  64'(o_dstM[1]),  64'h7);
    chk("l2_rd_valE",  o_valE[1],       64'h40);

    // LATENCY=3: reset in the middle of a call's WAIT must abort its write
    reset_pulse();
    run_op(2, 4'h4, 64'h100, 64'h9999, e);
    chk("l3_wr_edges", 64'(e), 64'd4);
    @(negedge clk);
    drive(4'h1, 4'h8, 64'h100, 64'h7777, 4'h4, 4'hF);
    @(posedge clk);
    #1 chk("l3_wait_stall0", 64'(o_stall[2]), 64'h1);
    @(posedge clk);
    #1 chk("l3_wait_stall1", 64'(o_stall[2]), 64'h1);
    #2 rst = 1'b1;
    #1;
    chk("l3_rst_icode", 64'(o_icode[2]), 64'h1);
    chk("l3_rst_stat",  64'(o_stat[2]),  64'h1);
    chk("l3_rst_valE",  o_valE[2],       64'h0);
    chk("l3_rst_dstE",  64'(o_dstE[2]),  64'hF);
    chk("l3_rst_stall", 64'(o_stall[2]), 64'h0);
    @(negedge clk);
    drive(4'h1, 4'h1, 64'h0, 64'h0, 4'hF, 4'hF);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("l3_idle_stall", 64'(o_stall[2]), 64'h0);
    run_op(2, 4'h5, 64'h100, 64'h0, e);
    chk("l3_rd_edges", 64'(e), 64'd4);
    chk("l3_rd_icode", 64'(o_icode[2]), 64'h5);
    chk("l3_rd_valM",  o_valM[2],       64'h9999);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
